// File: rtl/iso7816_pkg.sv
// Shared definitions for the ISO7816 line scheduler: FSM state encoding and timing constants.
package iso7816_pkg;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        TX    = 3'd1,
        RETRY = 3'd2,
        GUARD = 3'd3,
        RX    = 3'd4
    } lineStateT;

    localparam int RETRY_DELAY_ETU = 2;

    // The Tx core drives the I/O line while sending and while waiting to resend.
    function automatic logic ownsLine(input lineStateT s);
        return (s == TX) || (s == RETRY);
    endfunction

    // Only these states measure time in etu.
    function automatic logic tickerRuns(input lineStateT s);
        return (s == IDLE) || (s == GUARD) || (s == RETRY);
    endfunction

endpackage

// File: rtl/iso7816_etu_ticker.sv
// Elementary-time-unit ticker: counts 0..clocksPerBit and ticks on the last count.
module iso7816_etu_ticker #(
    parameter int WIDTH = 13
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             enable,
    input  logic             restart,
    input  logic [WIDTH-1:0] clocksPerBit,
    output logic             tick
);

    logic [WIDTH-1:0] countReg;

    always_ff @(posedge clk) begin
        if (reset || restart || !enable) begin
            countReg <= '0;
        end else if (countReg >= clocksPerBit) begin
            countReg <= '0;
        end else begin
            countReg <= countReg + WIDTH'(1);
        end
    end

    assign tick = enable && (countReg == clocksPerBit);

endmodule

// File: rtl/iso7816_line_scheduler.sv
// Half-duplex owner of the ISO7816 I/O line: arbitrates Tx/Rx, enforces guard time,
// retransmits on card error signal and flags character-waiting-time expiry.
module iso7816_line_scheduler
    import iso7816_pkg::*;
#(
    parameter int CLOCK_PER_BIT_WIDTH = 13,
    parameter int GT_WIDTH            = 8,
    parameter int WT_WIDTH            = 24,
    parameter int RETRY_WIDTH         = 2
) (
    input  logic                           clk,
    input  logic                           reset,
    input  logic [CLOCK_PER_BIT_WIDTH-1:0] clocksPerBit,
    input  logic [GT_WIDTH-1:0]            guardEtu,
    input  logic [WT_WIDTH-1:0]            waitEtu,
    input  logic [RETRY_WIDTH-1:0]         maxRetries,
    input  logic                           rxEnable,
    input  logic                           txReq,
    input  logic [7:0]                     txData,
    output logic                           txAck,
    output logic                           txDone,
    output logic                           txFail,
    output logic                           waitTimeout,
    output logic                           lineDirTx,
    output logic                           txCoreStart,
    output logic [7:0]                     txCoreData,
    input  logic                           txCoreEndOfTx,
    input  logic                           txCoreErrSig,
    input  logic                           rxCoreStartBit,
    input  logic                           rxCoreRun,
    input  logic                           rxCoreStopBit,
    input  logic                           rxCoreEndOfRx,
    output logic [2:0]                     state
);

    localparam int PULSE_COUNT = 5;

    lineStateT              stateReg, stateNext;
    logic [RETRY_WIDTH-1:0] retryReg, retryNext;
    logic [GT_WIDTH-1:0]    delayReg, delayNext;
    logic [WT_WIDTH-1:0]    wtReg, wtNext;
    logic [7:0]             dataReg, dataNext;
    logic                   lineDirReg, lineDirNext;
    logic [PULSE_COUNT-1:0] pulseReg, pulseNext;
    logic                   ackNext, startNext, doneNext, failNext, timeoutNext;
    logic                   etuTick;

    iso7816_etu_ticker #(.WIDTH(CLOCK_PER_BIT_WIDTH)) etuTicker (
        .clk          (clk),
        .reset        (reset),
        .enable       (tickerRuns(stateReg)),
        .restart      (stateNext != stateReg),
        .clocksPerBit (clocksPerBit),
        .tick         (etuTick)
    );

    always_comb begin
        stateNext   = stateReg;
        retryNext   = retryReg;
        delayNext   = delayReg;
        wtNext      = wtReg;
        dataNext    = dataReg;
        ackNext     = 1'b0;
        startNext   = 1'b0;
        doneNext    = 1'b0;
        failNext    = 1'b0;
        timeoutNext = 1'b0;

        case (stateReg)
            IDLE: begin
                // A card start bit owns the line first; txReq simply stays pending.
                if (rxCoreStartBit) begin
                    stateNext = RX;
                end else if (txReq) begin
                    stateNext = TX;
                    ackNext   = 1'b1;
                    startNext = 1'b1;
                    dataNext  = txData;
                    retryNext = '0;
                end
            end
            TX: begin
                if (txCoreEndOfTx) begin
                    if (!txCoreErrSig) begin
                        doneNext  = 1'b1;
                        wtNext    = '0;
                        stateNext = GUARD;
                    end else if (retryReg < maxRetries) begin
                        retryNext = retryReg + RETRY_WIDTH'(1);
                        stateNext = RETRY;
                    end else begin
                        failNext  = 1'b1;
                        wtNext    = '0;
                        stateNext = GUARD;
                    end
                end
            end
            RETRY: begin
                if (etuTick) begin
                    if (delayReg == GT_WIDTH'(RETRY_DELAY_ETU - 1)) begin
                        stateNext = TX;
                        startNext = 1'b1;
                    end else begin
                        delayNext = delayReg + GT_WIDTH'(1);
                    end
                end
            end
            GUARD: begin
                if (guardEtu == '0) begin
                    stateNext = IDLE;
                end else if (etuTick) begin
                    if (delayReg + GT_WIDTH'(1) == guardEtu) begin
                        stateNext = IDLE;
                    end else begin
                        delayNext = delayReg + GT_WIDTH'(1);
                    end
                end
            end
            RX: begin
                if (rxCoreEndOfRx) begin
                    stateNext = IDLE;
                    wtNext    = '0;
                end else if (!rxCoreStartBit && !rxCoreRun && !rxCoreStopBit) begin
                    stateNext = IDLE;
                end
            end
            default: stateNext = IDLE;
        endcase

        if (stateNext != stateReg) begin
            delayNext = '0;
        end

        // WT counter saturates at waitEtu so the timeout pulse fires only once per clear.
        if (stateNext == RX && stateReg != RX) begin
            wtNext = '0;
        end else if (!rxEnable) begin
            wtNext = '0;
        end else if (etuTick && (stateReg == IDLE || stateReg == GUARD)
                     && waitEtu != '0 && wtReg < waitEtu) begin
            wtNext = wtReg + WT_WIDTH'(1);
            if (wtReg + WT_WIDTH'(1) == waitEtu) begin
                timeoutNext = 1'b1;
            end
        end
    end

    assign lineDirNext = ownsLine(stateNext);
    assign pulseNext   = {timeoutNext, failNext, doneNext, startNext, ackNext};

    always_ff @(posedge clk) begin
        if (reset) begin
            stateReg   <= IDLE;
            retryReg   <= '0;
            delayReg   <= '0;
            wtReg      <= '0;
            dataReg    <= '0;
            lineDirReg <= 1'b0;
        end else begin
            stateReg   <= stateNext;
            retryReg   <= retryNext;
            delayReg   <= delayNext;
            wtReg      <= wtNext;
            dataReg    <= dataNext;
            lineDirReg <= lineDirNext;
        end
    end

    generate
        for (genvar gi = 0; gi < PULSE_COUNT; gi++) begin : gPulse
            always_ff @(posedge clk) begin
                if (reset) begin
                    pulseReg[gi] <= 1'b0;
                end else begin
                    pulseReg[gi] <= pulseNext[gi];
                end
            end
        end
    endgenerate

    assign txAck       = pulseReg[0];
    assign txCoreStart = pulseReg[1];
    assign txDone      = pulseReg[2];
    assign txFail      = pulseReg[3];
    assign waitTimeout = pulseReg[4];
    assign lineDirTx   = lineDirReg;
    assign txCoreData  = dataReg;
    assign state       = stateReg;

endmodule

// File: tb/tb_iso7816_line_scheduler.sv
// Scoreboard bench: expected pulse events are queued when stimulus is driven and
// matched in order against the pulses the scheduler produces.
module tb_iso7816_line_scheduler;
    import iso7816_pkg::*;

    localparam int EV_ACK     = 1;
    localparam int EV_START   = 2;
    localparam int EV_DONE    = 3;
    localparam int EV_FAIL    = 4;
    localparam int EV_TIMEOUT = 5;

    typedef struct {
        int         kind;
        int         cyc;
        logic [7:0] data;
    } evT;

    logic        clk = 1'b0;
    logic        reset;
    logic [12:0] clocksPerBit;
    logic [7:0]  guardEtu;
    logic [23:0] waitEtu;
    logic [1:0]  maxRetries;
    logic        rxEnable;
    logic        txReq;
    logic [7:0]  txData;
    logic        txAck, txDone, txFail, waitTimeout, lineDirTx, txCoreStart;
    logic [7:0]  txCoreData;
    logic        txCoreEndOfTx, txCoreErrSig;
    logic        rxCoreStartBit, rxCoreRun, rxCoreStopBit, rxCoreEndOfRx;
    logic [2:0]  state;

    int checks = 0;
    int failures = 0;
    int cyc = 0;
    evT expQ[$];

    iso7816_line_scheduler dut (
        .clk            (clk),
        .reset          (reset),
        .clocksPerBit   (clocksPerBit),
        .guardEtu       (guardEtu),
        .waitEtu        (waitEtu),
        .maxRetries     (maxRetries),
        .rxEnable       (rxEnable),
        .txReq          (txReq),
        .txData         (txData),
        .txAck          (txAck),
        .txDone         (txDone),
        .txFail         (txFail),
        .waitTimeout    (waitTimeout),
        .lineDirTx      (lineDirTx),
        .txCoreStart    (txCoreStart),
        .txCoreData     (txCoreData),
        .txCoreEndOfTx  (txCoreEndOfTx),
        .txCoreErrSig   (txCoreErrSig),
        .rxCoreStartBit (rxCoreStartBit),
        .rxCoreRun      (rxCoreRun),
        .rxCoreStopBit  (rxCoreStopBit),
        .rxCoreEndOfRx  (rxCoreEndOfRx),
        .state          (state)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic checkValue(input string tag, input logic [31:0] observed,
                              input logic [31:0] expected);
        checks++;
        if (observed !== expected) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, observed, expected, cyc);
        end
    endtask

    task automatic stepCycles(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic expectEvent(input int kind, input int atCyc, input logic [7:0] data);
        evT e;
        e.kind = kind;
        e.cyc  = atCyc;
        e.data = data;
        expQ.push_back(e);
    endtask

    // Every pulse the DUT raises must match the oldest expected event.
    always @(negedge clk) begin
        logic [4:0] pulses;
        pulses = {waitTimeout, txFail, txDone, txCoreStart, txAck};
        for (int k = 0; k < 5; k++) begin
            if (pulses[k]) begin
                if (expQ.size() == 0) begin
                    checkValue("unexpected_event", k + 1, 0);
                end else begin
                    evT e;
                    e = expQ.pop_front();
                    checkValue("event_kind", k + 1, e.kind);
                    checkValue("event_cycle", cyc, e.cyc);
                    if (k + 1 == EV_START) checkValue("core_data", txCoreData, e.data);
                    $display("event kind=%0d cycle=%0d data=0x%0h", k + 1, cyc, txCoreData);
                end
            end
        end
    end

    // Sends one character and finishes it cleanly, including the full guard wait.
    task automatic sendOk(input logic [7:0] ch);
        int d;
        txReq = 1'b1;
        txData = ch;
        expectEvent(EV_ACK, cyc + 1, 8'h00);
        expectEvent(EV_START, cyc + 1, ch);
        stepCycles(1);
        txReq = 1'b0;
        checkValue("tx_state", state, TX);
        checkValue("tx_linedir", lineDirTx, 1);
        stepCycles(4);
        d = cyc;
        txCoreEndOfTx = 1'b1;
        txCoreErrSig = 1'b0;
        expectEvent(EV_DONE, d + 1, 8'h00);
        stepCycles(1);
        txCoreEndOfTx = 1'b0;
        checkValue("guard_state", state, GUARD);
        checkValue("guard_linedir", lineDirTx, 0);
        stepCycles(7);
        checkValue("guard_last_cycle", state, GUARD);
        stepCycles(1);
        checkValue("guard_exit_idle", state, IDLE);
    endtask

    initial begin
        int d;
        int e;
        int g;
        reset = 1'b1;
        clocksPerBit = 13'd3;
        guardEtu = 8'd2;
        waitEtu = 24'd0;
        maxRetries = 2'd2;
        rxEnable = 1'b0;
        txReq = 1'b0;
        txData = 8'h00;
        txCoreEndOfTx = 1'b0;
        txCoreErrSig = 1'b0;
        rxCoreStartBit = 1'b0;
        rxCoreRun = 1'b0;
        rxCoreStopBit = 1'b0;
        rxCoreEndOfRx = 1'b0;
        stepCycles(3);
        checkValue("reset_state", state, IDLE);
        checkValue("reset_linedir", lineDirTx, 0);
        checkValue("reset_coredata", txCoreData, 0);
        checkValue("reset_pulses", {waitTimeout, txFail, txDone, txCoreStart, txAck}, 0);
        reset = 1'b0;
        stepCycles(2);

        // Clean send of 'h3B.
        sendOk(8'h3B);
        stepCycles(2);

        // Error signal on every attempt: two resends then failure.
        txReq = 1'b1;
        txData = 8'h55;
        expectEvent(EV_ACK, cyc + 1, 8'h00);
        expectEvent(EV_START, cyc + 1, 8'h55);
        stepCycles(1);
        txReq = 1'b0;
        for (int k = 0; k < 3; k++) begin
            stepCycles(3);
            d = cyc;
            txCoreEndOfTx = 1'b1;
            txCoreErrSig = 1'b1;
            if (k < 2) expectEvent(EV_START, d + 9, 8'h55);
            else       expectEvent(EV_FAIL, d + 1, 8'h00);
            stepCycles(1);
            txCoreEndOfTx = 1'b0;
            txCoreErrSig = 1'b0;
            if (k < 2) begin
                checkValue("retry_state", state, RETRY);
                checkValue("retry_linedir", lineDirTx, 1);
                stepCycles(7);
                checkValue("retry_gap_end", state, RETRY);
                stepCycles(1);
                checkValue("retry_back_tx", state, TX);
            end else begin
                checkValue("fail_guard", state, GUARD);
                stepCycles(8);
                checkValue("fail_idle", state, IDLE);
            end
        end
        stepCycles(2);

        // Start bit and txReq together: Rx wins, txReq served afterwards.
        rxCoreStartBit = 1'b1;
        txReq = 1'b1;
        txData = 8'hA5;
        stepCycles(1);
        checkValue("collide_rx", state, RX);
        rxCoreStartBit = 1'b0;
        rxCoreRun = 1'b1;
        stepCycles(3);
        checkValue("collide_hold_rx", state, RX);
        e = cyc;
        rxCoreRun = 1'b0;
        rxCoreEndOfRx = 1'b1;
        expectEvent(EV_ACK, e + 2, 8'h00);
        expectEvent(EV_START, e + 2, 8'hA5);
        stepCycles(1);
        rxCoreEndOfRx = 1'b0;
        checkValue("rx_exit_idle", state, IDLE);
        stepCycles(1);
        txReq = 1'b0;
        checkValue("pending_tx", state, TX);
        stepCycles(2);
        d = cyc;
        txCoreEndOfTx = 1'b1;
        expectEvent(EV_DONE, d + 1, 8'h00);
        stepCycles(1);
        txCoreEndOfTx = 1'b0;
        stepCycles(10);

        // WT expiry 20 clocks after end of reception, once only.
        rxEnable = 1'b1;
        waitEtu = 24'd5;
        rxCoreStartBit = 1'b1;
        stepCycles(1);
        rxCoreStartBit = 1'b0;
        rxCoreRun = 1'b1;
        stepCycles(3);
        e = cyc;
        rxCoreRun = 1'b0;
        rxCoreEndOfRx = 1'b1;
        expectEvent(EV_TIMEOUT, e + 21, 8'h00);
        stepCycles(1);
        rxCoreEndOfRx = 1'b0;
        stepCycles(60);

        // Start-bit glitch: back to IDLE without a reception.
        g = cyc;
        rxCoreStartBit = 1'b1;
        expectEvent(EV_TIMEOUT, g + 23, 8'h00);
        stepCycles(1);
        checkValue("glitch_rx", state, RX);
        stepCycles(1);
        rxCoreStartBit = 1'b0;
        stepCycles(1);
        checkValue("glitch_idle", state, IDLE);
        stepCycles(40);

        // waitEtu=0 disables the timeout entirely.
        rxEnable = 1'b0;
        stepCycles(1);
        rxEnable = 1'b1;
        waitEtu = 24'd0;
        stepCycles(60);
        rxEnable = 1'b0;

        // Reset in the middle of a character.
        txReq = 1'b1;
        txData = 8'hC3;
        expectEvent(EV_ACK, cyc + 1, 8'h00);
        expectEvent(EV_START, cyc + 1, 8'hC3);
        stepCycles(1);
        txReq = 1'b0;
        stepCycles(2);
        reset = 1'b1;
        stepCycles(1);
        reset = 1'b0;
        checkValue("midreset_state", state, IDLE);
        checkValue("midreset_linedir", lineDirTx, 0);
        checkValue("midreset_coredata", txCoreData, 0);
        checkValue("midreset_pulses", {waitTimeout, txFail, txDone, txCoreStart, txAck}, 0);
        stepCycles(5);

        checkValue("events_outstanding", expQ.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
